// File: rtl/queue_reader.sv
// Read side of the entry queue. It holds only the read pointer, the occupancy and a sticky
// overflow flag. The head entry is taken straight from the writer's storage array and is
// presented on a valid/ready interface.
module queue_reader #(
  parameter int unsigned num_entries = 8,
  parameter int unsigned bit_width   = 8
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [num_entries-1:0][bit_width-1:0]      entries,
  input  logic                                       push,
  input  logic [$clog2(num_entries)-1:0]             wrPtr_q,
  input  logic                                       flush,
  input  logic                                       out_ready,
  output logic                                       out_valid,
  output logic [bit_width-1:0]                       out_data,
  output logic [$clog2(num_entries)-1:0]             rdPtr_q,
  output logic [$clog2(num_entries)-1:0]             rdPtr_d,
  output logic [$clog2(num_entries):0]               count,
  output logic                                       empty,
  output logic                                       full,
  output logic                                       overflow
);

  localparam int unsigned PtrW = $clog2(num_entries);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] CountFull = CntW'(num_entries);

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            pop;

  assign out_valid = (count_q != '0);
  assign out_data  = entries[rd_ptr_q];
  assign empty     = (count_q == '0);
  assign full      = (count_q == CountFull);
  assign pop       = out_valid & out_ready & ~flush;

  assign rdPtr_q  = rd_ptr_q;
  assign rdPtr_d  = rd_ptr_d;
  assign count    = count_q;
  assign overflow = ovf_q;

  // Next-state: flush resyncs to the writer and wins over push/pop; otherwise track push/pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      // A push in the flush cycle lands at wrPtr_q, so the slot after it becomes the head.
      rd_ptr_d = wrPtr_q + PtrW'(push);
      count_d  = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          count_d = count_q + CntW'(1);
        end
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_queue_reader.sv
// Bench for queue_reader: a small writer model feeds the storage array, the driver pushes
// expected head values into a scoreboard queue, and a negedge monitor pops and compares.
module tb_queue_reader;

  localparam int N = 8;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [N-1:0][7:0]   entries;
  logic                push = 1'b0;
  logic [2:0]          wr_ptr;
  logic                flush = 1'b0;
  logic                out_ready = 1'b0;
  logic                out_valid;
  logic [7:0]          out_data;
  logic [2:0]          rd_ptr_q, rd_ptr_d;
  logic [3:0]          count;
  logic                empty, full, overflow;
  logic [7:0]          din = 8'h00;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  int         mcount = 0;
  int         movf = 0;
  bit         unrel = 1'b0;

  always #5 clk = ~clk;

  queue_reader #(.num_entries(N), .bit_width(8)) dut (
    .clk(clk), .reset(reset), .entries(entries), .push(push), .wrPtr_q(wr_ptr),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .rdPtr_q(rd_ptr_q), .rdPtr_d(rd_ptr_d), .count(count), .empty(empty), .full(full),
    .overflow(overflow)
  );

  // Writer model: stores on push, pointer advances modulo depth.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 3'd0;
    end else if (push) begin
      entries[wr_ptr] <= din;
      wr_ptr <= wr_ptr + 3'd1;
    end
  end

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: compare DUT against the queue model, then advance the model for this cycle.
  always @(negedge clk) begin
    logic [2:0] m_rd;
    logic [2:0] m_rd_next;
    logic [7:0] head;
    bit         do_pop;
    if (reset) begin
      mcount = 0;
      movf = 0;
      unrel = 1'b0;
      exp_q.delete();
    end else begin
      chk("out_valid", int'(out_valid), int'(mcount != 0));
      chk("count", int'(count), mcount);
      chk("empty", int'(empty), int'(mcount == 0));
      chk("full", int'(full), int'(mcount == N));
      chk("overflow", int'(overflow), movf);
      m_rd = wr_ptr - 3'(mcount);
      do_pop = (mcount != 0) && out_ready && !flush;
      if (!unrel) begin
        chk("rdPtr_q", int'(rd_ptr_q), int'(m_rd));
      end
      m_rd_next = flush ? (wr_ptr + 3'(push)) : (m_rd + 3'(do_pop));
      if (!unrel || flush) begin
        chk("rdPtr_d", int'(rd_ptr_d), int'(m_rd_next));
      end
      if (do_pop && exp_q.size() != 0) begin
        head = exp_q.pop_front();
        if (!unrel) chk("out_data", int'(out_data), int'(head));
      end
      if (flush) begin
        mcount = 0;
        unrel = 1'b0;
        exp_q.delete();
      end else if (push && !do_pop) begin
        if (mcount == N) begin
          movf = 1;
          unrel = 1'b1;
        end else begin
          mcount++;
        end
      end else if (do_pop && !push) begin
        mcount--;
      end
    end
  end

  // One cycle of stimulus, applied just after the rising edge.
  task automatic step(input logic p, input logic r, input logic f, input logic [7:0] d);
    @(posedge clk);
    #1;
    push = p;
    out_ready = r;
    flush = f;
    din = d;
    if (p) exp_q.push_back(d);
  endtask

  task automatic do_reset();
    push = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    do_reset();

    // Reset mid-traffic with count=5: outputs clear immediately.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
    step(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("pre_reset_count", int'(count), 5);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_count", int'(count), 0);
    chk("reset_rdptr", int'(rd_ptr_q), 0);
    do_reset();

    // Fill with 0x10..0x17, then drain on consecutive cycles.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
    step(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("fill_count", int'(count), 8);
    chk("fill_full", int'(full), 1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("drain_empty", int'(empty), 1);
    chk("drain_rdptr", int'(rd_ptr_q), 0);

    // Push and pop together with the read pointer at 7.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    step(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("wrap_pre_count", int'(count), 3);
    chk("wrap_pre_rdptr", int'(rd_ptr_q), 7);
    step(1'b1, 1'b1, 1'b0, 8'($urandom));
    step(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("wrap_count", int'(count), 3);
    chk("wrap_rdptr", int'(rd_ptr_q), 0);

    // Overflow: push while full, flag survives a full drain.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    step(1'b1, 1'b0, 1'b0, 8'hEE);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("ovf_count", int'(count), 8);
    chk("ovf_flag", int'(overflow), 1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("ovf_sticky", int'(overflow), 1);
    chk("ovf_drained", int'(empty), 1);
    do_reset();

    // Flush with push at wrPtr=6, count=4.
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    step(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("flush_pre_count", int'(count), 4);
    chk("flush_pre_wrptr", int'(wr_ptr), 6);
    step(1'b1, 1'b0, 1'b1, 8'h77);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("flush_count", int'(count), 0);
    chk("flush_rdptr", int'(rd_ptr_q), 7);
    chk("flush_valid", int'(out_valid), 0);

    // Single push into empty queue: valid one cycle later with the right data.
    step(1'b1, 1'b0, 1'b0, 8'hA5);
    @(negedge clk);
    chk("lat_valid_n", int'(out_valid), 0);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    chk("lat_valid_n1", int'(out_valid), 1);
    chk("lat_data", int'(out_data), 8'hA5);

    // Randomised traffic including flushes and occasional overflow.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 15) == 0), 8'($urandom));
    end
    step(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
